// File: rtl/processor_defines.sv
`default_nettype none
// ============================================================================
// Package     : processor_defines
// Description : Store-path definitions shared by execute and the store
//               buffer: store_control encodings (SD included), the buffered
//               store entry, and the lane-alignment helper that places store
//               data and byte enables into their memory lanes.
// Revision    : 1.0 - store-buffer version of the store path
// ============================================================================
package processor_defines;

  // Widest supported datapath; entries are sized for it and narrower
  // configurations keep the upper bits at zero.
  localparam int MAX_XLEN = 64;
  localparam int MAX_BE   = MAX_XLEN / 8;

  typedef enum logic [2:0] {
    STR_NOP = 3'd0,
    STR_SB  = 3'd1,
    STR_SH  = 3'd2,
    STR_SW  = 3'd3,
    STR_SD  = 3'd4
  } store_control_e;

  typedef struct packed {
    logic [MAX_XLEN-1:0] addr;
    logic [MAX_XLEN-1:0] data;
    logic [MAX_BE-1:0]   byte_en;
  } st_entry_t;

  typedef struct packed {
    logic [MAX_XLEN-1:0] data;
    logic [MAX_BE-1:0]   byte_en;
  } lane_t;

  // Shift store data and byte enables into the lanes selected by the byte
  // offset. Unused lanes stay zero.
  function automatic lane_t align_store(input logic [2:0]          ctrl,
                                        input logic [MAX_XLEN-1:0] rs2,
                                        input logic [2:0]          off);
    lane_t r;
    r = '0;
    case (ctrl)
      STR_SB: begin
        r.byte_en = 8'h01 << off;
        r.data    = {56'b0, rs2[7:0]} << {off, 3'b000};
      end
      STR_SH: begin
        r.byte_en = 8'h03 << off;
        r.data    = {48'b0, rs2[15:0]} << {off, 3'b000};
      end
      STR_SW: begin
        r.byte_en = 8'h0F << off;
        r.data    = {32'b0, rs2[31:0]} << {off, 3'b000};
      end
      STR_SD: begin
        r.byte_en = '1;
        r.data    = rs2;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_buffer_unit_if.sv
`default_nettype none
// ============================================================================
// Interface   : store_buffer_unit_if
// Description : Bundles the execute-side store handshake, the data-memory
//               request/grant port, the load-hazard probe and the occupancy
//               status of store_buffer_unit.
//               slave  : the store buffer itself
//               master : the surrounding pipeline / memory / load unit
// Revision    : 1.0 - initial interface
// ============================================================================
interface store_buffer_unit_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int BEW = XLEN / 8;
  localparam int CW  = $clog2(DEPTH) + 1;

  // execute side
  logic            i_st_valid;
  logic            o_st_ready;
  logic [2:0]      i_store_control;
  logic [XLEN-1:0] i_rs1_val;
  logic [XLEN-1:0] i_rs2_val;
  logic [XLEN-1:0] i_imm;
  logic            o_stall_pc;
  logic            o_misaligned;
  // data-memory side
  logic            o_mem_req;
  logic            i_mem_gnt;
  logic            o_mem_rw_mode;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_write_data;
  logic [BEW-1:0]  o_mem_byte_en;
  // load-unit probe
  logic            i_ld_valid;
  logic [XLEN-1:0] i_ld_addr;
  logic            o_ld_hazard;
  // status
  logic [CW-1:0]   o_count;
  logic            o_empty;

  modport slave (
    input  i_st_valid, i_store_control, i_rs1_val, i_rs2_val, i_imm,
    input  i_mem_gnt, i_ld_valid, i_ld_addr,
    output o_st_ready, o_stall_pc, o_misaligned,
    output o_mem_req, o_mem_rw_mode, o_mem_addr, o_mem_write_data, o_mem_byte_en,
    output o_ld_hazard, o_count, o_empty
  );

  modport master (
    output i_st_valid, i_store_control, i_rs1_val, i_rs2_val, i_imm,
    output i_mem_gnt, i_ld_valid, i_ld_addr,
    input  o_st_ready, o_stall_pc, o_misaligned,
    input  o_mem_req, o_mem_rw_mode, o_mem_addr, o_mem_write_data, o_mem_byte_en,
    input  o_ld_hazard, o_count, o_empty
  );
endinterface
`default_nettype wire

// File: rtl/store_buffer_unit_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : DEPTH-entry synchronous FIFO of ENTRY_T. Besides the usual
//               push/pop/full/empty/count it exposes per-slot valid bits and
//               the stored addresses so the owner can compare all entries.
// Ports       : i_clk, i_rst (async, active-low)
//               i_push/i_push_data  enqueue (ignored when full)
//               i_pop               dequeue head (ignored when empty)
//               o_head              registered head entry
//               o_full/o_empty/o_count  occupancy
//               o_valid/o_addr      per-slot valid bit and address
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
  import processor_defines::*;
#(
  parameter type ENTRY_T = st_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_push,
  input  ENTRY_T                           i_push_data,
  input  logic                             i_pop,
  output ENTRY_T                           o_head,
  output logic                             o_full,
  output logic                             o_empty,
  output logic [$clog2(DEPTH):0]           o_count,
  output logic [DEPTH-1:0]                 o_valid,
  output logic [DEPTH-1:0][MAX_XLEN-1:0]   o_addr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ENTRY_T           mem_q [DEPTH];
  ENTRY_T           mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             w_push, w_pop;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // wr == rd only when full or empty, so a push and a pop never hit the
  // same slot in one cycle.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(w_push) - CW'(w_pop);
    if (w_push) begin
      mem_d[wr_ptr_q]   = i_push_data;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    if (w_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;
  assign o_valid = valid_q;

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_addr
      assign o_addr[g] = mem_q[g].addr;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/store_buffer_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer_unit
// Description : Store unit with a posted-write buffer. Computes the effective
//               address, lane-aligned data and byte enables of each store,
//               queues legal stores in a DEPTH-entry FIFO and drains them in
//               program order over a request/grant memory port. Flags loads
//               that hit a word with a buffered store.
// Ports       : i_clk  clock
//               i_rst  asynchronous, active-low reset
//               sbu    store_buffer_unit_if.slave (execute handshake, memory
//                      port, load probe, occupancy)
// Revision    : 1.0 - replaces the single-cycle stalling store path
// ============================================================================
module store_buffer_unit
  import processor_defines::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  store_buffer_unit_if.slave sbu
);
  localparam int BEW  = XLEN / 8;
  localparam int OFFW = $clog2(BEW);
  localparam int CW   = $clog2(DEPTH) + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } drain_state_e;

  logic [XLEN-1:0]                 w_ea;
  logic [2:0]                      w_off;
  logic                            w_bad, w_nop, w_accept, w_push, w_pop;
  lane_t                           w_lane;
  st_entry_t                       w_entry, w_head;
  logic                            w_full, w_empty;
  logic [CW-1:0]                   w_count;
  logic [DEPTH-1:0]                w_valid;
  logic [DEPTH-1:0][MAX_XLEN-1:0]  w_addr;
  logic                            w_hazard;
  drain_state_e                    state_q, state_d;
  logic                            mem_req_q, mem_req_d;
  logic                            unused_bits;

  // ---------------------------------------------------------------- address
  assign w_ea  = sbu.i_rs1_val + sbu.i_imm;
  assign w_off = 3'(w_ea[OFFW-1:0]);

  always_comb begin
    w_nop = 1'b0;
    w_bad = 1'b0;
    case (sbu.i_store_control)
      STR_NOP: w_nop = 1'b1;
      STR_SB:  w_bad = 1'b0;
      STR_SH:  w_bad = w_ea[0];
      STR_SW:  w_bad = |w_ea[1:0];
      STR_SD:  w_bad = (XLEN != 64) || (|w_ea[OFFW-1:0]);
      default: w_bad = 1'b1;
    endcase
  end

  // Misaligned and NOP ops are consumed but never reach the buffer.
  assign w_accept         = sbu.i_st_valid && sbu.o_st_ready;
  assign w_push           = w_accept && !w_bad && !w_nop;
  assign sbu.o_misaligned = sbu.i_st_valid && w_bad;
  assign sbu.o_st_ready   = !w_full;
  assign sbu.o_stall_pc   = sbu.i_st_valid && !sbu.o_st_ready;

  assign w_lane          = align_store(sbu.i_store_control, MAX_XLEN'(sbu.i_rs2_val), w_off);
  assign w_entry.addr    = MAX_XLEN'({w_ea[XLEN-1:OFFW], {OFFW{1'b0}}});
  assign w_entry.data    = w_lane.data;
  assign w_entry.byte_en = w_lane.byte_en;

  // ------------------------------------------------------------------- FIFO
  sync_fifo #(
    .ENTRY_T (st_entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_data (w_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_valid     (w_valid),
    .o_addr      (w_addr)
  );

  // ------------------------------------------------------------ drain FSM
  // After a grant the FSM stays in REQ whenever something is left to send,
  // including a store pushed in the grant cycle, so back-to-back grants
  // drain one store per cycle.
  always_comb begin
    state_d   = state_q;
    mem_req_d = mem_req_q;
    w_pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!w_empty) begin
          state_d   = S_REQ;
          mem_req_d = 1'b1;
        end
      end
      S_REQ: begin
        if (sbu.i_mem_gnt) begin
          w_pop = 1'b1;
          if (!((w_count > CW'(1)) || w_push)) begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
    end
  end

  // Head fields come from FIFO storage; they are masked to zero outside a
  // request so the port idles at its reset values.
  assign sbu.o_mem_req        = mem_req_q;
  assign sbu.o_mem_rw_mode    = !mem_req_q;
  assign sbu.o_mem_addr       = mem_req_q ? w_head.addr[XLEN-1:0]   : '0;
  assign sbu.o_mem_write_data = mem_req_q ? w_head.data[XLEN-1:0]   : '0;
  assign sbu.o_mem_byte_en    = mem_req_q ? w_head.byte_en[BEW-1:0] : '0;

  // ---------------------------------------------------------------- hazard
  // Word-granular compare against every occupied slot; a store being
  // enqueued this cycle is not yet in a slot and is not seen.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_addr[i][XLEN-1:OFFW] == sbu.i_ld_addr[XLEN-1:OFFW]))
        w_hazard = 1'b1;
    end
  end
  assign sbu.o_ld_hazard = sbu.i_ld_valid && w_hazard;

  assign sbu.o_count = w_count;
  assign sbu.o_empty = w_empty;

  // Upper entry bits (narrow XLEN) and word-offset bits are intentionally
  // ignored.
  assign unused_bits = ^{w_head, w_addr, sbu.i_ld_addr};

endmodule
`default_nettype wire

// File: tb/tb_store_buffer_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer_unit
// Description : Self-checking bench for store_buffer_unit (XLEN=32, DEPTH=4).
//               Expected memory writes are queued as stores are accepted and
//               compared as the memory port grants them.
// Revision    : 1.0 - initial bench
// ============================================================================
module tb_store_buffer_unit;
  import processor_defines::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_buffer_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH)) sbu();

  store_buffer_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .sbu   (sbu)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour of one store op at XLEN=32.
  function automatic void model(input logic [2:0] ctrl, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [31:0] imm,
                                output exp_t e, output bit mis, output bit enq);
    logic [31:0] ea;
    int          off;
    ea     = rs1 + imm;
    off    = int'(ea[1:0]);
    e.addr = {ea[31:2], 2'b00};
    e.data = '0;
    e.be   = '0;
    mis    = 1'b0;
    enq    = 1'b0;
    case (ctrl)
      3'd0: ;
      3'd1: begin e.be = 4'b0001 << off; e.data = {24'b0, rs2[7:0]} << (8 * off); enq = 1'b1; end
      3'd2: if (ea[0]) mis = 1'b1;
            else begin e.be = 4'b0011 << off; e.data = {16'b0, rs2[15:0]} << (8 * off); enq = 1'b1; end
      3'd3: if (off != 0) mis = 1'b1;
            else begin e.be = 4'hF; e.data = rs2; enq = 1'b1; end
      default: mis = 1'b1;
    endcase
  endfunction

  // Presents one op for a single edge; checks handshake flags in the cycle
  // it is presented and queues the expected write when it is accepted.
  task automatic drive_op(input logic [2:0] ctrl, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] imm,
                          input bit exp_ready, input string tag);
    exp_t e;
    bit   mis, enq;
    model(ctrl, rs1, rs2, imm, e, mis, enq);
    sbu.i_st_valid      = 1'b1;
    sbu.i_store_control = ctrl;
    sbu.i_rs1_val       = rs1;
    sbu.i_rs2_val       = rs2;
    sbu.i_imm           = imm;
    #1;
    check_value({tag, "_misaligned"}, 64'(sbu.o_misaligned), 64'(mis));
    check_value({tag, "_ready"},      64'(sbu.o_st_ready),   64'(exp_ready));
    check_value({tag, "_stall"},      64'(sbu.o_stall_pc),   64'(!exp_ready));
    if (exp_ready && enq) exp_q.push_back(e);
    @(posedge clk);
    #1;
    sbu.i_st_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_count"},  64'(sbu.o_count),          64'(0));
    check_value({tag, "_empty"},  64'(sbu.o_empty),          64'(1));
    check_value({tag, "_req"},    64'(sbu.o_mem_req),        64'(0));
    check_value({tag, "_rw"},     64'(sbu.o_mem_rw_mode),    64'(1));
    check_value({tag, "_addr"},   64'(sbu.o_mem_addr),       64'(0));
    check_value({tag, "_data"},   64'(sbu.o_mem_write_data), 64'(0));
    check_value({tag, "_be"},     64'(sbu.o_mem_byte_en),    64'(0));
    check_value({tag, "_hazard"}, 64'(sbu.o_ld_hazard),      64'(0));
  endtask

  // Memory-side scoreboard: a write completes at the edge following a
  // sample with req && gnt.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sbu.o_mem_req && sbu.i_mem_gnt) begin
      if (exp_q.size() == 0) begin
        check_value("spurious_write", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check_value("wr_addr", 64'(sbu.o_mem_addr),       64'(e.addr));
        check_value("wr_data", 64'(sbu.o_mem_write_data), 64'(e.data));
        check_value("wr_be",   64'(sbu.o_mem_byte_en),    64'(e.be));
        check_value("wr_rw",   64'(sbu.o_mem_rw_mode),    64'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] rs1;
    logic [31:0] imm;
  } mis_t;

  initial begin
    mis_t mis_tab[5];
    mis_tab[0] = '{3'd3, 32'h2000, 32'd2};  // SW at 0x2002
    mis_tab[1] = '{3'd2, 32'h2000, 32'd1};  // SH odd
    mis_tab[2] = '{3'd4, 32'h2000, 32'd0};  // SD at XLEN=32
    mis_tab[3] = '{3'd7, 32'h2000, 32'd0};  // undefined encoding
    mis_tab[4] = '{3'd0, 32'h2000, 32'd1};  // NOP

    sbu.i_st_valid      = 1'b0;
    sbu.i_store_control = '0;
    sbu.i_rs1_val       = '0;
    sbu.i_rs2_val       = '0;
    sbu.i_imm           = '0;
    sbu.i_mem_gnt       = 1'b0;
    sbu.i_ld_valid      = 1'b0;
    sbu.i_ld_addr       = '0;

    // ---- reset state
    #3;
    check_reset_outputs("reset");
    check_value("reset_ready", 64'(sbu.o_st_ready), 64'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // ---- SB with one-cycle enqueue-to-request latency
    drive_op(3'd1, 32'h1000, 32'h0000_00AB, 32'd3, 1'b1, "sb");
    check_value("sb_count",     64'(sbu.o_count),   64'(1));
    check_value("sb_req_early", 64'(sbu.o_mem_req), 64'(0));
    tick();
    check_value("sb_req",  64'(sbu.o_mem_req),        64'(1));
    check_value("sb_addr", 64'(sbu.o_mem_addr),       64'h1000);
    check_value("sb_be",   64'(sbu.o_mem_byte_en),    64'h8);
    check_value("sb_data", 64'(sbu.o_mem_write_data), 64'hAB00_0000);
    sbu.i_mem_gnt = 1'b1;
    tick();
    sbu.i_mem_gnt = 1'b0;
    check_value("sb_done_count", 64'(sbu.o_count),   64'(0));
    check_value("sb_done_req",   64'(sbu.o_mem_req), 64'(0));

    // ---- misaligned / undefined / NOP ops are consumed without effect
    foreach (mis_tab[i])
      drive_op(mis_tab[i].ctrl, mis_tab[i].rs1, 32'h1234_5678, mis_tab[i].imm, 1'b1,
               $sformatf("mis%0d", i));
    check_value("mis_count", 64'(sbu.o_count), 64'(0));
    tick();
    check_value("mis_req", 64'(sbu.o_mem_req), 64'(0));

    // ---- fill to DEPTH with grant held low, then drain one per cycle
    for (int i = 0; i < DEPTH; i++)
      drive_op(3'd3, 32'h4000, 32'hC0DE_0000 + 32'(i), 32'(4 * i), 1'b1, "fill");
    check_value("full_count", 64'(sbu.o_count),    64'(DEPTH));
    check_value("full_ready", 64'(sbu.o_st_ready), 64'(0));
    drive_op(3'd3, 32'h4100, 32'hDEAD_BEEF, 32'd0, 1'b0, "fifth");
    check_value("fifth_count", 64'(sbu.o_count), 64'(DEPTH));
    sbu.i_mem_gnt = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      check_value("drain_req",   64'(sbu.o_mem_req), 64'(1));
      check_value("drain_count", 64'(sbu.o_count),   64'(DEPTH - k));
      tick();
    end
    sbu.i_mem_gnt = 1'b0;
    check_value("drain_empty", 64'(sbu.o_empty),   64'(1));
    check_value("drain_idle",  64'(sbu.o_mem_req), 64'(0));

    // ---- simultaneous push and pop at count 2, pointers wrap
    drive_op(3'd3, 32'h6000, 32'h0600_0001, 32'd0, 1'b1, "pp_pre");
    drive_op(3'd3, 32'h6000, 32'h0600_0002, 32'd4, 1'b1, "pp_pre");
    check_value("pp_req",   64'(sbu.o_mem_req), 64'(1));
    check_value("pp_count", 64'(sbu.o_count),   64'(2));
    sbu.i_mem_gnt = 1'b1;
    for (int j = 0; j < 5; j++) begin
      drive_op(3'd1, 32'h6100, 32'h0000_0070 + 32'(j), 32'(j), 1'b1, "pp");
      check_value("pp_count_hold", 64'(sbu.o_count), 64'(2));
    end
    tick();
    tick();
    sbu.i_mem_gnt = 1'b0;
    check_value("pp_drained", 64'(sbu.o_count), 64'(0));

    // ---- load hazard against a buffered SH at 0x3006
    drive_op(3'd2, 32'h3000, 32'h0000_1234, 32'd6, 1'b1, "sh");
    sbu.i_ld_valid = 1'b1;
    sbu.i_ld_addr  = 32'h3004;
    #1 check_value("hz_hit", 64'(sbu.o_ld_hazard), 64'(1));
    sbu.i_ld_addr  = 32'h3008;
    #1 check_value("hz_miss", 64'(sbu.o_ld_hazard), 64'(0));
    sbu.i_ld_valid = 1'b0;
    sbu.i_ld_addr  = 32'h3004;
    #1 check_value("hz_novalid", 64'(sbu.o_ld_hazard), 64'(0));
    tick();
    check_value("sh_addr", 64'(sbu.o_mem_addr),       64'h3004);
    check_value("sh_be",   64'(sbu.o_mem_byte_en),    64'hC);
    check_value("sh_data", 64'(sbu.o_mem_write_data), 64'h1234_0000);
    sbu.i_ld_valid = 1'b1;
    sbu.i_mem_gnt  = 1'b1;
    #1 check_value("hz_grant_cycle", 64'(sbu.o_ld_hazard), 64'(1));
    tick();
    sbu.i_mem_gnt = 1'b0;
    #1 check_value("hz_after_grant", 64'(sbu.o_ld_hazard), 64'(0));
    sbu.i_ld_valid = 1'b0;

    // ---- asynchronous reset with three entries while requesting
    for (int i = 0; i < 3; i++)
      drive_op(3'd1, 32'h5000, 32'h0000_0050 + 32'(i), 32'(i), 1'b1, "rst_fill");
    check_value("rst_pre_req",   64'(sbu.o_mem_req), 64'(1));
    check_value("rst_pre_count", 64'(sbu.o_count),   64'(3));
    #2;
    rst_n          = 1'b0;
    sbu.i_mem_gnt  = 1'b1;
    sbu.i_ld_valid = 1'b1;
    sbu.i_ld_addr  = 32'h5000;
    exp_q.delete();
    #1 check_reset_outputs("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    sbu.i_ld_valid = 1'b0;
    tick();
    tick();
    tick();
    check_value("post_rst_req",   64'(sbu.o_mem_req), 64'(0));
    check_value("post_rst_count", 64'(sbu.o_count),   64'(0));
    sbu.i_mem_gnt = 1'b0;
    tick();

    check_value("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
